// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: outcome decode, mispredict/redirect generation,
// and a direct-mapped BTB with 2-bit saturating counters read by IF and trained from EX.
module branch_resolve_unit #(
    parameter int IDX_W = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_if_pred_taken,
    output logic [31:0] o_if_pred_target,
    input  logic        i_ex_valid,
    input  logic        i_ex_stall,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_is_jalr,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             br_legal, br_taken, taken, res, mispred;
    logic [1:0]       ctr_cur, ctr_inc, ctr_dec;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{i_if_pc[1:0], i_ex_pc[1:0]};

    assign if_idx = i_if_pc[IDX_W+1:2];
    assign if_tag = i_if_pc[31:IDX_W+2];
    assign ex_idx = i_ex_pc[IDX_W+1:2];
    assign ex_tag = i_ex_pc[31:IDX_W+2];

    // Lookup sees pre-update contents when IF and EX hit the same index.
    assign if_hit           = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign o_if_pred_taken  = if_hit && ctr_q[if_idx][1];
    assign o_if_pred_target = if_hit ? target_q[if_idx] : 32'd0;

    assign o_br_un = ~i_ex_funct3[1];

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (i_ex_funct3)
            3'b000:         br_taken = i_br_equal;
            3'b001:         br_taken = ~i_br_equal;
            3'b100, 3'b110: br_taken = i_br_less;
            3'b101, 3'b111: br_taken = ~i_br_less;
            default:        br_legal = 1'b0;
        endcase
    end

    assign taken = i_ex_is_br ? br_taken : (i_ex_is_jal | i_ex_is_jalr);

    // Gating with reset discards any resolve presented while reset is held.
    assign res = i_rst_n & i_ex_valid & ~i_ex_stall &
                 (i_ex_is_jal | i_ex_is_jalr | (i_ex_is_br & br_legal));

    assign mispred = res & ((taken != i_ex_pred_taken) |
                            (taken & i_ex_pred_taken & (i_ex_target != i_ex_pred_target)));

    assign o_flush       = mispred;
    assign o_redirect_pc = taken ? i_ex_target : (i_ex_pc + 32'd4);

    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ctr_cur = ctr_q[ex_idx];
    assign ctr_inc = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
    assign ctr_dec = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (res) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= taken ? ctr_inc : ctr_dec;
            end else if (taken) begin
                valid_q[ex_idx] <= 1'b1;
                ctr_q[ex_idx]   <= 2'b10;
            end
        end
    end

    // NOTE: tag/target storage is left unreset; valid bits alone guard it, which keeps it RAM-friendly.
    always_ff @(posedge i_clk) begin
        if (res && taken) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= i_ex_target;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_br_count      <= '0;
            o_mispred_count <= '0;
        end else if (res) begin
            o_br_count <= o_br_count + 32'd1;
            if (mispred) o_mispred_count <= o_mispred_count + 32'd1;
        end
    end
endmodule
